// File: rtl/rv_wb_pkg.sv
// Shared types and constants for the write-back stage.
package rv_wb_pkg;

    typedef enum logic [1:0] {
        SEL_PC_PLUS4 = 2'd0,
        SEL_ALU_OUT  = 2'd1,
        SEL_DMEM     = 2'd2
    } t_sel_wb;

    typedef enum logic {
        IDLE     = 1'b0,
        WAIT_RSP = 1'b1
    } t_wb_state;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;

endpackage

// File: rtl/rv_wb_ld_align.sv
// Load formatter: selects byte/half/word from an aligned word and extends it.
module rv_ld_align (
    input  logic [31:0] raw_data,
    input  logic [2:0]  funct3,
    input  logic [1:0]  off,
    output logic [31:0] ld_data
);
    import rv_wb_pkg::*;

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        case (off)
            2'd0:    byte_v = raw_data[7:0];
            2'd1:    byte_v = raw_data[15:8];
            2'd2:    byte_v = raw_data[23:16];
            default: byte_v = raw_data[31:24];
        endcase
        half_v = off[1] ? raw_data[31:16] : raw_data[15:0];
    end

    // Reserved funct3 encodings fall back to a full-word load.
    always_comb begin
        case (funct3)
            LB:      ld_data = {{24{byte_v[7]}}, byte_v};
            LH:      ld_data = {{16{half_v[15]}}, half_v};
            LBU:     ld_data = {24'h0, byte_v};
            LHU:     ld_data = {16'h0, half_v};
            default: ld_data = raw_data;
        endcase
    end

endmodule

// File: rtl/rv_wb.sv
// Write-back stage: load formatting, D_MEM response wait/timeout, RF write port.
module rv_wb #(
    parameter int RSP_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_Q104H,
    input  logic        rd_wr_en_Q104H,
    input  logic [4:0]  rd_addr_Q104H,
    input  logic [1:0]  sel_wb_Q104H,
    input  logic [2:0]  ld_funct3_Q104H,
    input  logic [1:0]  ld_off_Q104H,
    input  logic [31:0] pre_wb_data_Q104H,
    input  logic        dmem_rsp_valid,
    input  logic [31:0] dmem_rsp_data,
    output logic        stall_Q104H,
    output logic        rf_wr_en_Q105H,
    output logic [4:0]  rf_wr_addr_Q105H,
    output logic [31:0] rf_wr_data_Q105H,
    output logic        load_err,
    output logic        spurious_rsp
);
    import rv_wb_pkg::*;

    localparam logic [7:0] TIMEOUT_CNT = 8'(RSP_TIMEOUT);

    t_wb_state   state, state_nxt;
    logic [7:0]  cnt, cnt_nxt;
    logic        is_load;
    logic        stall_c;
    logic        timeout;
    logic        spur_nxt;
    logic        commit;
    logic [31:0] ld_data;
    logic [31:0] wb_data;

    rv_ld_align u_ld_align (
        .raw_data (dmem_rsp_data),
        .funct3   (ld_funct3_Q104H),
        .off      (ld_off_Q104H),
        .ld_data  (ld_data)
    );

    assign is_load = valid_Q104H && (t_sel_wb'(sel_wb_Q104H) == SEL_DMEM);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        stall_c   = 1'b0;
        timeout   = 1'b0;
        spur_nxt  = dmem_rsp_valid && !is_load;
        case (state)
            IDLE: begin
                if (is_load && !dmem_rsp_valid) begin
                    stall_c   = 1'b1;
                    state_nxt = WAIT_RSP;
                    cnt_nxt   = 8'd1;
                end
            end
            default: begin
                if (!is_load) begin
                    // Flush: any response racing the flush is dropped silently.
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                    spur_nxt  = 1'b0;
                end else if (dmem_rsp_valid) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else if (cnt == TIMEOUT_CNT) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                    timeout   = 1'b1;
                end else begin
                    stall_c   = 1'b1;
                    cnt_nxt   = cnt + 8'd1;
                end
            end
        endcase
    end

    assign stall_Q104H = stall_c && !rst;
    assign commit      = valid_Q104H && !stall_c;

    always_comb begin
        wb_data = pre_wb_data_Q104H;
        if (t_sel_wb'(sel_wb_Q104H) == SEL_DMEM)
            wb_data = timeout ? '0 : ld_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rf_wr_en_Q105H   <= 1'b0;
            rf_wr_addr_Q105H <= '0;
            rf_wr_data_Q105H <= '0;
            load_err         <= 1'b0;
            spurious_rsp     <= 1'b0;
        end else begin
            rf_wr_en_Q105H <= commit && rd_wr_en_Q104H && (rd_addr_Q104H != 5'd0);
            if (commit) begin
                rf_wr_addr_Q105H <= rd_addr_Q104H;
                rf_wr_data_Q105H <= wb_data;
            end
            load_err     <= timeout;
            spurious_rsp <= spur_nxt;
        end
    end

endmodule

// File: tb/tb_rv_wb.sv
// Directed vector table plus multi-cycle sequences for the write-back stage.
module tb_rv_wb;
    import rv_wb_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_Q104H;
    logic        rd_wr_en_Q104H;
    logic [4:0]  rd_addr_Q104H;
    logic [1:0]  sel_wb_Q104H;
    logic [2:0]  ld_funct3_Q104H;
    logic [1:0]  ld_off_Q104H;
    logic [31:0] pre_wb_data_Q104H;
    logic        dmem_rsp_valid;
    logic [31:0] dmem_rsp_data;
    logic        stall_Q104H;
    logic        rf_wr_en_Q105H;
    logic [4:0]  rf_wr_addr_Q105H;
    logic [31:0] rf_wr_data_Q105H;
    logic        load_err;
    logic        spurious_rsp;

    int checks = 0;
    int errors = 0;

    rv_wb #(.RSP_TIMEOUT(16)) dut (
        .clk               (clk),
        .rst               (rst),
        .valid_Q104H       (valid_Q104H),
        .rd_wr_en_Q104H    (rd_wr_en_Q104H),
        .rd_addr_Q104H     (rd_addr_Q104H),
        .sel_wb_Q104H      (sel_wb_Q104H),
        .ld_funct3_Q104H   (ld_funct3_Q104H),
        .ld_off_Q104H      (ld_off_Q104H),
        .pre_wb_data_Q104H (pre_wb_data_Q104H),
        .dmem_rsp_valid    (dmem_rsp_valid),
        .dmem_rsp_data     (dmem_rsp_data),
        .stall_Q104H       (stall_Q104H),
        .rf_wr_en_Q105H    (rf_wr_en_Q105H),
        .rf_wr_addr_Q105H  (rf_wr_addr_Q105H),
        .rf_wr_data_Q105H  (rf_wr_data_Q105H),
        .load_err          (load_err),
        .spurious_rsp      (spurious_rsp)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        valid;
        logic [1:0]  sel;
        logic [2:0]  f3;
        logic [1:0]  off;
        logic        we;
        logic [4:0]  rd;
        logic [31:0] pre;
        logic        rv;
        logic [31:0] rdata;
        logic        e_en;
        logic [4:0]  e_addr;
        logic [31:0] e_data;
        logic        e_spur;
    } vec_t;

    vec_t vecs[21];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [1:0] sel, input logic [2:0] f3,
                         input logic [1:0] off, input logic we, input logic [4:0] rd,
                         input logic [31:0] pre, input logic rv, input logic [31:0] rdata);
        valid_Q104H       = v;
        sel_wb_Q104H      = sel;
        ld_funct3_Q104H   = f3;
        ld_off_Q104H      = off;
        rd_wr_en_Q104H    = we;
        rd_addr_Q104H     = rd;
        pre_wb_data_Q104H = pre;
        dmem_rsp_valid    = rv;
        dmem_rsp_data     = rdata;
    endtask

    task automatic idle();
        drive(1'b0, SEL_ALU_OUT, 3'b000, 2'd0, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0);
    endtask

    localparam logic [31:0] R = 32'h80FF7F01;
    localparam logic [1:0] SA = SEL_ALU_OUT;
    localparam logic [1:0] SP = SEL_PC_PLUS4;
    localparam logic [1:0] SD = SEL_DMEM;

    initial begin
        int n;
        vecs[0]  = '{1'b1, SA, 3'b000, 2'd0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 32'h0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0};
        vecs[1]  = '{1'b1, SP, 3'b000, 2'd0, 1'b1, 5'd1, 32'h00000104, 1'b0, 32'h0, 1'b1, 5'd1, 32'h00000104, 1'b0};
        vecs[2]  = '{1'b1, SD, LB,     2'd3, 1'b1, 5'd7, 32'h00000003, 1'b1, R,     1'b1, 5'd7, 32'hFFFFFF80, 1'b0};
        vecs[3]  = '{1'b1, SD, LBU,    2'd3, 1'b1, 5'd7, 32'h00000003, 1'b1, R,     1'b1, 5'd7, 32'h00000080, 1'b0};
        vecs[4]  = '{1'b1, SD, LB,     2'd0, 1'b1, 5'd8, 32'h0,        1'b1, R,     1'b1, 5'd8, 32'h00000001, 1'b0};
        vecs[5]  = '{1'b1, SD, LB,     2'd1, 1'b1, 5'd8, 32'h1,        1'b1, R,     1'b1, 5'd8, 32'h0000007F, 1'b0};
        vecs[6]  = '{1'b1, SD, LB,     2'd2, 1'b1, 5'd8, 32'h2,        1'b1, R,     1'b1, 5'd8, 32'hFFFFFFFF, 1'b0};
        vecs[7]  = '{1'b1, SD, LBU,    2'd2, 1'b1, 5'd8, 32'h2,        1'b1, R,     1'b1, 5'd8, 32'h000000FF, 1'b0};
        vecs[8]  = '{1'b1, SD, LH,     2'd2, 1'b1, 5'd9, 32'h2,        1'b1, R,     1'b1, 5'd9, 32'hFFFF80FF, 1'b0};
        vecs[9]  = '{1'b1, SD, LH,     2'd3, 1'b1, 5'd9, 32'h3,        1'b1, R,     1'b1, 5'd9, 32'hFFFF80FF, 1'b0};
        vecs[10] = '{1'b1, SD, LH,     2'd0, 1'b1, 5'd9, 32'h0,        1'b1, R,     1'b1, 5'd9, 32'h00007F01, 1'b0};
        vecs[11] = '{1'b1, SD, LHU,    2'd2, 1'b1, 5'd9, 32'h2,        1'b1, R,     1'b1, 5'd9, 32'h000080FF, 1'b0};
        vecs[12] = '{1'b1, SD, LW,     2'd1, 1'b1, 5'd3, 32'h1,        1'b1, R,     1'b1, 5'd3, 32'h80FF7F01, 1'b0};
        vecs[13] = '{1'b1, SD, 3'b011, 2'd2, 1'b1, 5'd3, 32'h2,        1'b1, R,     1'b1, 5'd3, 32'h80FF7F01, 1'b0};
        vecs[14] = '{1'b1, SD, 3'b110, 2'd0, 1'b1, 5'd3, 32'h0,        1'b1, R,     1'b1, 5'd3, 32'h80FF7F01, 1'b0};
        vecs[15] = '{1'b1, SA, 3'b000, 2'd0, 1'b0, 5'd6, 32'h11111111, 1'b0, 32'h0, 1'b0, 5'd6, 32'h11111111, 1'b0};
        vecs[16] = '{1'b1, SA, 3'b000, 2'd0, 1'b1, 5'd0, 32'h22222222, 1'b0, 32'h0, 1'b0, 5'd0, 32'h22222222, 1'b0};
        vecs[17] = '{1'b0, SA, 3'b000, 2'd0, 1'b1, 5'd4, 32'h33333333, 1'b0, 32'h0, 1'b0, 5'd0, 32'h22222222, 1'b0};
        vecs[18] = '{1'b1, SA, 3'b000, 2'd0, 1'b1, 5'd4, 32'h44444444, 1'b1, R,     1'b1, 5'd4, 32'h44444444, 1'b1};
        vecs[19] = '{1'b0, SA, 3'b000, 2'd0, 1'b1, 5'd4, 32'h55555555, 1'b1, R,     1'b0, 5'd4, 32'h44444444, 1'b1};
        vecs[20] = '{1'b1, SD, LH,     2'd0, 1'b1, 5'd2, 32'h0,        1'b1, 32'h12348001, 1'b1, 5'd2, 32'hFFFF8001, 1'b0};

        rst = 1'b1;
        idle();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_en", 32'(rf_wr_en_Q105H), 32'h0);
        chk("rst_addr", 32'(rf_wr_addr_Q105H), 32'h0);
        chk("rst_data", rf_wr_data_Q105H, 32'h0);
        chk("rst_err", 32'(load_err), 32'h0);
        chk("rst_spur", 32'(spurious_rsp), 32'h0);
        chk("rst_stall", 32'(stall_Q104H), 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // Single-cycle vectors: stall must stay low, results one edge later.
        for (int i = 0; i < 21; i++) begin
            @(negedge clk);
            drive(vecs[i].valid, vecs[i].sel, vecs[i].f3, vecs[i].off, vecs[i].we,
                  vecs[i].rd, vecs[i].pre, vecs[i].rv, vecs[i].rdata);
            #1;
            chk($sformatf("vec%0d_stall", i), 32'(stall_Q104H), 32'h0);
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_en", i), 32'(rf_wr_en_Q105H), 32'(vecs[i].e_en));
            chk($sformatf("vec%0d_addr", i), 32'(rf_wr_addr_Q105H), 32'(vecs[i].e_addr));
            chk($sformatf("vec%0d_data", i), rf_wr_data_Q105H, vecs[i].e_data);
            chk($sformatf("vec%0d_spur", i), 32'(spurious_rsp), 32'(vecs[i].e_spur));
            chk($sformatf("vec%0d_err", i), 32'(load_err), 32'h0);
        end

        // LH with response on wait cycle 3.
        @(negedge clk);
        drive(1'b1, SD, LH, 2'd2, 1'b1, 5'd9, 32'h2, 1'b0, 32'h80015A5A);
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("lh3_stall%0d", k), 32'(stall_Q104H), 32'h1);
            @(posedge clk);
            #1;
            chk($sformatf("lh3_noen%0d", k), 32'(rf_wr_en_Q105H), 32'h0);
            @(negedge clk);
        end
        dmem_rsp_valid = 1'b1;
        #1;
        chk("lh3_stall_rel", 32'(stall_Q104H), 32'h0);
        @(posedge clk);
        #1;
        chk("lh3_en", 32'(rf_wr_en_Q105H), 32'h1);
        chk("lh3_addr", 32'(rf_wr_addr_Q105H), 32'd9);
        chk("lh3_data", rf_wr_data_Q105H, 32'hFFFF8001);
        chk("lh3_spur", 32'(spurious_rsp), 32'h0);
        @(negedge clk);
        idle();

        // Timeout: count stall cycles, bounded.
        @(negedge clk);
        drive(1'b1, SD, LW, 2'd0, 1'b1, 5'd10, 32'h0, 1'b0, 32'hAAAAAAAA);
        n = 0;
        for (int c = 0; c < 40; c++) begin
            #1;
            if (!stall_Q104H) break;
            n++;
            @(negedge clk);
        end
        chk("to_stall_cycles", 32'(n), 32'd16);
        @(posedge clk);
        #1;
        chk("to_en", 32'(rf_wr_en_Q105H), 32'h1);
        chk("to_addr", 32'(rf_wr_addr_Q105H), 32'd10);
        chk("to_data", rf_wr_data_Q105H, 32'h0);
        chk("to_err", 32'(load_err), 32'h1);
        @(negedge clk);
        idle();
        @(posedge clk);
        #1;
        chk("to_err_pulse", 32'(load_err), 32'h0);
        chk("to_en_after", 32'(rf_wr_en_Q105H), 32'h0);

        // Flush during wait, then a late response.
        @(negedge clk);
        drive(1'b1, SD, LW, 2'd0, 1'b1, 5'd11, 32'h0, 1'b0, 32'h0);
        #1;
        chk("fl_stall0", 32'(stall_Q104H), 32'h1);
        @(negedge clk);
        #1;
        chk("fl_stall1", 32'(stall_Q104H), 32'h1);
        valid_Q104H = 1'b0;
        #1;
        chk("fl_stall_drop", 32'(stall_Q104H), 32'h0);
        @(posedge clk);
        #1;
        chk("fl_noen", 32'(rf_wr_en_Q105H), 32'h0);
        chk("fl_nospur", 32'(spurious_rsp), 32'h0);
        @(negedge clk);
        dmem_rsp_valid = 1'b1;
        dmem_rsp_data  = 32'h12345678;
        @(posedge clk);
        #1;
        chk("late_spur", 32'(spurious_rsp), 32'h1);
        chk("late_noen", 32'(rf_wr_en_Q105H), 32'h0);
        @(negedge clk);
        dmem_rsp_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("late_spur_pulse", 32'(spurious_rsp), 32'h0);

        // Flush coinciding with a response: dropped, not spurious.
        @(negedge clk);
        drive(1'b1, SD, LW, 2'd0, 1'b1, 5'd11, 32'h0, 1'b0, 32'h0);
        @(negedge clk);
        valid_Q104H    = 1'b0;
        dmem_rsp_valid = 1'b1;
        #1;
        chk("flr_stall", 32'(stall_Q104H), 32'h0);
        @(posedge clk);
        #1;
        chk("flr_nospur", 32'(spurious_rsp), 32'h0);
        chk("flr_noen", 32'(rf_wr_en_Q105H), 32'h0);
        @(negedge clk);
        idle();

        // Load to x0 with one wait cycle.
        @(negedge clk);
        drive(1'b1, SD, LW, 2'd0, 1'b1, 5'd0, 32'h0, 1'b0, 32'hCAFEF00D);
        #1;
        chk("x0_stall", 32'(stall_Q104H), 32'h1);
        @(posedge clk);
        #1;
        chk("x0_noen0", 32'(rf_wr_en_Q105H), 32'h0);
        @(negedge clk);
        dmem_rsp_valid = 1'b1;
        #1;
        chk("x0_stall_rel", 32'(stall_Q104H), 32'h0);
        @(posedge clk);
        #1;
        chk("x0_noen1", 32'(rf_wr_en_Q105H), 32'h0);
        chk("x0_err", 32'(load_err), 32'h0);
        @(negedge clk);
        idle();

        // Reset in the middle of a wait.
        @(negedge clk);
        drive(1'b1, SA, 3'b000, 2'd0, 1'b1, 5'd13, 32'h00000055, 1'b0, 32'h0);
        @(posedge clk);
        #1;
        chk("pre_rst_data", rf_wr_data_Q105H, 32'h00000055);
        @(negedge clk);
        drive(1'b1, SD, LW, 2'd0, 1'b1, 5'd12, 32'h0, 1'b0, 32'h0);
        @(negedge clk);
        #1;
        chk("mr_stall", 32'(stall_Q104H), 32'h1);
        rst = 1'b1;
        valid_Q104H = 1'b0;
        @(posedge clk);
        #1;
        chk("mr_en", 32'(rf_wr_en_Q105H), 32'h0);
        chk("mr_addr", 32'(rf_wr_addr_Q105H), 32'h0);
        chk("mr_data", rf_wr_data_Q105H, 32'h0);
        chk("mr_err", 32'(load_err), 32'h0);
        chk("mr_spur", 32'(spurious_rsp), 32'h0);
        chk("mr_stall_low", 32'(stall_Q104H), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        drive(1'b1, SD, LW, 2'd0, 1'b1, 5'd14, 32'h0, 1'b1, 32'h12345678);
        #1;
        chk("post_rst_stall", 32'(stall_Q104H), 32'h0);
        @(posedge clk);
        #1;
        chk("post_rst_en", 32'(rf_wr_en_Q105H), 32'h1);
        chk("post_rst_addr", 32'(rf_wr_addr_Q105H), 32'd14);
        chk("post_rst_data", rf_wr_data_Q105H, 32'h12345678);
        @(negedge clk);
        idle();
        @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rv_wb.md
Name: rv_wb

Overview:
- Write-back stage of the pipeline, directly downstream of the memory-access stage.
- Consumes the pre-write-back data (PC+4 or ALU result) and the D_MEM load response; formats loads by size, offset and sign, and writes the register file.
- Holds the pipeline (stall) while a load response is outstanding from a variable-latency D_MEM.
- Provides the committed value to the forwarding unit.

Parameters:
- RSP_TIMEOUT, 16, max cycles waited for dmem_rsp_valid after a load enters Q104H (2..255).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- valid_Q104H  in  1  instruction present in Q104H
- rd_wr_en_Q104H  in  1  instruction writes rd
- rd_addr_Q104H  in  5  destination register
- sel_wb_Q104H  in  2  t_sel_wb: SEL_PC_PLUS4, SEL_ALU_OUT, SEL_DMEM
- ld_funct3_Q104H  in  3  LB=000, LH=001, LW=010, LBU=100, LHU=101
- ld_off_Q104H  in  2  byte offset, alu_out[1:0]
- pre_wb_data_Q104H  in  32  data from memory-access stage
- dmem_rsp_valid  in  1  load data valid this cycle
- dmem_rsp_data  in  32  raw aligned 32-bit word
- stall_Q104H  out  1  freeze Q100H..Q104H registers this cycle
- rf_wr_en_Q105H  out  1  register-file write enable
- rf_wr_addr_Q105H  out  5  register-file write address
- rf_wr_data_Q105H  out  32  register-file write data
- load_err  out  1  one-cycle pulse on load timeout
- spurious_rsp  out  1  one-cycle pulse on unexpected response

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; timeout counter 0.
- Commit:
  - The Q104H instruction commits in the cycle where valid_Q104H=1 and stall_Q104H=0.
  - On commit, register rf_wr_en_Q105H = rd_wr_en_Q104H && rd_addr_Q104H!=0, plus the address and data, on the next clk edge.
  - Latency is 1 cycle from commit to the RF write outputs.
  - Without a commit, rf_wr_en_Q105H is 0 on the next cycle; addr and data hold their last values.
- Non-load (sel_wb != SEL_DMEM): data = pre_wb_data_Q104H; stall_Q104H = 0.
- Load data formatting (sel_wb = SEL_DMEM):
  - Byte = dmem_rsp_data[8*off +: 8].
  - Half = dmem_rsp_data[16*off[1] +: 16]; off[0] is ignored.
  - Word = full 32 bits; off is ignored.
  - LB/LH sign-extend; LBU/LHU zero-extend.
  - Any other funct3 is treated as LW.
- FSM states: IDLE, WAIT_RSP.
  - IDLE, load, dmem_rsp_valid=1: commit formatted data, stall=0, stay in IDLE.
  - IDLE, load, dmem_rsp_valid=0: stall=1 (combinational), go to WAIT_RSP, counter=1.
  - WAIT_RSP, dmem_rsp_valid=1: formatting uses the held Q104H inputs (frozen by stall); commit, stall=0, go to IDLE, counter=0.
  - WAIT_RSP, no response, counter<RSP_TIMEOUT: stall=1, counter++.
  - WAIT_RSP, no response, counter==RSP_TIMEOUT: stall=0, commit data 32'h0, load_err=1 for one cycle, go to IDLE.
- Spurious response: dmem_rsp_valid=1 while not (valid_Q104H && sel_wb==SEL_DMEM) gives spurious_rsp=1 for one cycle; the data is discarded.
- valid_Q104H=0 in WAIT_RSP (flush): go to IDLE, counter=0, no commit, stall=0.
- A response arriving in the same cycle as the flush is discarded; spurious_rsp is not raised.
- rd=x0: writes suppressed; load timing and stall are unchanged.
- rst asserted mid-wait: next cycle IDLE; all outputs 0.

Decomposition:
- pkg gets:
  - t_sel_wb (2-bit enum: SEL_PC_PLUS4, SEL_ALU_OUT, SEL_DMEM); extends the existing select enum.
  - t_wb_state enum (IDLE, WAIT_RSP).
  - Load funct3 localparams (LB, LH, LW, LBU, LHU).
- One sub-module: rv_ld_align, purely combinational. Inputs raw word, funct3, offset; output formatted 32-bit data.
- All flops use the existing DFF macros with synchronous reset.

Test Plan:
- ALU write: sel=SEL_ALU_OUT, rd=5, pre_wb=32'hDEADBEEF -> next cycle rf_wr_en=1, addr=5, data=DEADBEEF; stall never 1.
- Zero-latency LB: rsp_valid=1 same cycle, data=32'h80FF7F01, off=3 -> data=FFFFFF80, stall=0. Repeat with LBU -> 00000080.
- 3-cycle load LH: off=2, data=32'h8001xxxx arriving at wait cycle 3 -> stall=1 for exactly 3 cycles, then data=FFFF8001.
- Timeout: load with no response, RSP_TIMEOUT=16 -> stall=1 for 16 cycles, then load_err pulse, rf_wr_data=0, FSM IDLE.
- Flush and spurious:
  - Flush during WAIT_RSP -> no RF write; stall drops the same cycle.
  - A response the next cycle -> spurious_rsp=1, no write.
- x0 and reset:
  - Load with rd=0 -> rf_wr_en stays 0.
  - rst during WAIT_RSP -> all outputs 0 next cycle; the following load behaves normally.
